// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes, protection width and the
// response selection helper used by the register file.
package axil_pkg;

    localparam int AXI_LITE_PROT_W = 3;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axil_resp_e;

    // In-range accesses are always OKAY; misses only error when enabled.
    function automatic axil_resp_e access_resp(input logic in_range, input logic err_en);
        return (in_range || !err_en) ? RESP_OKAY : RESP_SLVERR;
    endfunction

endpackage

// File: rtl/axil_wstrb_merge.sv
// Byte-lane merge: each strobe bit selects the new byte, otherwise the old
// byte is kept. Purely combinational.
module axil_wstrb_merge #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   old_data,
    input  logic [DATA_W-1:0]   new_data,
    input  logic [DATA_W/8-1:0] strb,
    output logic [DATA_W-1:0]   merged
);

    for (genvar b = 0; b < DATA_W/8; b++) begin : g_lane
        assign merged[b*8 +: 8] = strb[b] ? new_data[b*8 +: 8] : old_data[b*8 +: 8];
    end

endmodule

// File: rtl/axil_regfile.sv
// AXI4-Lite slave register file with independent AW/W capture and concurrent
// read path. Define AXIL_REGFILE_SLVERR_EN to answer out-of-range accesses with SLVERR.
module axil_regfile
    import axil_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int NUM_REGS = 4
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    // AR
    input  logic [ADDR_W-1:0]          s_axi_araddr,
    input  logic [AXI_LITE_PROT_W-1:0] s_axi_arprot,
    input  logic                       s_axi_arvalid,
    output logic                       s_axi_arready,
    // R
    output logic [DATA_W-1:0]          s_axi_rdata,
    output logic [1:0]                 s_axi_rresp,
    output logic                       s_axi_rvalid,
    input  logic                       s_axi_rready,
    // AW
    input  logic [ADDR_W-1:0]          s_axi_awaddr,
    input  logic [AXI_LITE_PROT_W-1:0] s_axi_awprot,
    input  logic                       s_axi_awvalid,
    output logic                       s_axi_awready,
    // W
    input  logic [DATA_W-1:0]          s_axi_wdata,
    input  logic [DATA_W/8-1:0]        s_axi_wstrb,
    input  logic                       s_axi_wvalid,
    output logic                       s_axi_wready,
    // B
    output logic [1:0]                 s_axi_bresp,
    output logic                       s_axi_bvalid,
    input  logic                       s_axi_bready,
    // register side
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic [NUM_REGS-1:0]        wr_pulse_o
);

    localparam int STRB_W = DATA_W/8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_W - OFFS;

`ifdef AXIL_REGFILE_SLVERR_EN
    localparam logic SLVERR_EN = 1'b1;
`else
    localparam logic SLVERR_EN = 1'b0;
`endif

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [NUM_REGS-1:0]             wr_pulse;
    logic [NUM_REGS-1:0]             ar_hit, aw_hit, aw_hit_q;

    logic              aw_pending, w_pending;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;

    logic              bvalid, rvalid;
    logic [DATA_W-1:0] rdata;
    axil_resp_e        bresp, rresp;

    logic [IDX_W-1:0]  ar_idx, aw_idx;
    logic [DATA_W-1:0] rd_val, wr_old, wr_merged;
    logic              aw_hs, w_hs, ar_hs, commit;

    // Byte offset bits and protection attributes carry no meaning here.
    logic unused;
    assign unused = ^{s_axi_arprot, s_axi_awprot,
                      s_axi_araddr[OFFS-1:0], s_axi_awaddr[OFFS-1:0]};

    assign ar_idx = s_axi_araddr[ADDR_W-1:OFFS];
    assign aw_idx = s_axi_awaddr[ADDR_W-1:OFFS];

    // One-hot decode; an all-zero vector means the index is out of range.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_dec
        assign ar_hit[i] = (ar_idx == IDX_W'(i));
        assign aw_hit[i] = (aw_idx == IDX_W'(i));
    end

    assign s_axi_awready = ~aw_pending & ~bvalid;
    assign s_axi_wready  = ~w_pending  & ~bvalid;
    assign s_axi_arready = ~rvalid;

    assign aw_hs  = s_axi_awvalid & s_axi_awready;
    assign w_hs   = s_axi_wvalid  & s_axi_wready;
    assign ar_hs  = s_axi_arvalid & s_axi_arready;
    assign commit = aw_pending & w_pending & ~bvalid;

    always_comb begin
        rd_val = '0;
        wr_old = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_hit[i])   rd_val = rd_val | regs[i];
            if (aw_hit_q[i]) wr_old = wr_old | regs[i];
        end
    end

    axil_wstrb_merge #(
        .DATA_W (DATA_W)
    ) u_merge (
        .old_data (wr_old),
        .new_data (w_data_q),
        .strb     (w_strb_q),
        .merged   (wr_merged)
    );

    // Write channel capture and B response.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_pending <= 1'b0;
            w_pending  <= 1'b0;
            aw_hit_q   <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid     <= 1'b0;
            bresp      <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_pending <= 1'b1;
                aw_hit_q   <= aw_hit;
            end
            if (w_hs) begin
                w_pending <= 1'b1;
                w_data_q  <= s_axi_wdata;
                w_strb_q  <= s_axi_wstrb;
            end
            if (commit) begin
                aw_pending <= 1'b0;
                w_pending  <= 1'b0;
                bvalid     <= 1'b1;
                bresp      <= access_resp(|aw_hit_q, SLVERR_EN);
            end else if (bvalid && s_axi_bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    // Register storage; a miss leaves aw_hit_q zero so nothing is touched.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            regs     <= '0;
            wr_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                wr_pulse[i] <= commit & aw_hit_q[i];
                if (commit && aw_hit_q[i]) regs[i] <= wr_merged;
            end
        end
    end

    // Read path samples regs before any same-edge commit lands.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else begin
            if (ar_hs) begin
                rvalid <= 1'b1;
                rdata  <= rd_val;
                rresp  <= access_resp(|ar_hit, SLVERR_EN);
            end else if (rvalid && s_axi_rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    assign s_axi_bvalid = bvalid;
    assign s_axi_bresp  = bresp;
    assign s_axi_rvalid = rvalid;
    assign s_axi_rdata  = rdata;
    assign s_axi_rresp  = rresp;
    assign regs_o       = regs;
    assign wr_pulse_o   = wr_pulse;

endmodule
